// File: rtl/bit_scanner_if.sv
// Scan request/result bundle for bit_scanner.
// The requester owns start/mode/vec; the scanner owns busy/done and the results.
interface bit_scanner_if #(
    parameter int WIDTH = 32
);
    localparam int IDXW = $clog2(WIDTH);

    logic            start;
    logic            mode;
    logic [WIDTH-1:0] vec;
    logic            busy;
    logic            done;
    logic            found;
    logic [IDXW-1:0] index;
    logic [IDXW:0]   count;

    modport master (
        output start, mode, vec,
        input  busy, done, found, index, count
    );

    modport slave (
        input  start, mode, vec,
        output busy, done, found, index, count
    );
endinterface

// File: rtl/bit_scanner.sv
// Multi-cycle first-set-bit finder and population counter.
// Scans a latched vector CHUNK bits per cycle, lowest-first or highest-first.
module bit_scanner #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input logic       clk,
    input logic       reset,
    bit_scanner_if.slave bus
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = $clog2(WIDTH);
    localparam int CW   = $clog2(CHUNK);
    localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [WIDTH-1:0] vec_r, vec_nxt;
    logic            mode_r, mode_nxt;
    logic            found_r, found_nxt;
    logic [IDXW-1:0] index_r, index_nxt;
    logic [IDXW:0]   count_r, count_nxt;
    logic            busy_r, done_r;

    logic [PW-1:0]   csel;
    logic [IDXW-1:0] base;
    logic [CHUNK-1:0] chunk;
    logic            hit;
    logic [IDXW-1:0] pos;
    logic [IDXW:0]   pc;

    // Select the current chunk and find its priority bit and popcount.
    always_comb begin
        csel  = mode_r ? (PW'(NCH - 1) - ptr) : ptr;
        base  = IDXW'(csel) << CW;
        chunk = vec_r[base +: CHUNK];
        hit   = |chunk;
        pos   = '0;
        pc    = '0;
        if (mode_r) begin
            for (int i = 0; i < CHUNK; i++)
                if (chunk[i]) pos = IDXW'(i);
        end else begin
            for (int i = CHUNK - 1; i >= 0; i--)
                if (chunk[i]) pos = IDXW'(i);
        end
        for (int i = 0; i < CHUNK; i++)
            pc = pc + (IDXW + 1)'(chunk[i]);
    end

    // Next-state and next-result logic for the scan FSM.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        vec_nxt   = vec_r;
        mode_nxt  = mode_r;
        found_nxt = found_r;
        index_nxt = index_r;
        count_nxt = count_r;
        unique case (state)
            IDLE, DONE: begin
                if (state == DONE)
                    state_nxt = IDLE;
                if (bus.start) begin
                    state_nxt = SCAN;
                    vec_nxt   = bus.vec;
                    mode_nxt  = bus.mode;
                    ptr_nxt   = '0;
                    found_nxt = 1'b0;
                    index_nxt = '0;
                    count_nxt = '0;
                end
            end
            SCAN: begin
                count_nxt = count_r + pc;
                if (!found_r && hit) begin
                    found_nxt = 1'b1;
                    index_nxt = base + pos;
                end
                if (ptr == PW'(NCH - 1)) begin
                    state_nxt = DONE;
                end else begin
                    ptr_nxt = ptr + PW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and result registers; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            vec_r   <= '0;
            mode_r  <= 1'b0;
            found_r <= 1'b0;
            index_r <= '0;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            vec_r   <= vec_nxt;
            mode_r  <= mode_nxt;
            found_r <= found_nxt;
            index_r <= index_nxt;
            count_r <= count_nxt;
            busy_r  <= (state_nxt == SCAN);
            done_r  <= (state_nxt == DONE);
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.found = found_r;
    assign bus.index = index_r;
    assign bus.count = count_r;
endmodule

// File: tb/tb_bit_scanner.sv
// Scoreboard bench for bit_scanner (WIDTH=32, CHUNK=4).
// Expected results are queued at start and checked on each done pulse.
module tb_bit_scanner;
    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    typedef struct {
        logic       found;
        logic [4:0] index;
        logic [5:0] count;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t last_exp;

    bit_scanner_if #(.WIDTH(WIDTH)) bus ();

    bit_scanner #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(logic [31:0] v, logic m);
        exp_t e;
        e.found = |v;
        e.index = '0;
        e.count = '0;
        e.cyc   = 0;
        for (int i = 0; i < 32; i++) e.count = e.count + 6'(v[i]);
        if (!m) begin
            for (int i = 31; i >= 0; i--) if (v[i]) e.index = 5'(i);
        end else begin
            for (int i = 0; i < 32; i++) if (v[i]) e.index = 5'(i);
        end
        return e;
    endfunction

    task automatic push(logic [31:0] v, logic m);
        exp_t e;
        e = model(v, m);
        e.cyc = cyc + 1 + NCH;
        sb.push_back(e);
    endtask

    // Check every done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                last_exp = e;
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("found", 64'(bus.found), 64'(e.found));
                chk("index", 64'(bus.index), 64'(e.index));
                chk("count", 64'(bus.count), 64'(e.count));
                chk("busy_at_done", 64'(bus.busy), 0);
            end
        end
    end

    task automatic run_scan(logic [31:0] v, logic m);
        @(negedge clk);
        bus.start = 1'b1;
        bus.vec   = v;
        bus.mode  = m;
        push(v, m);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic check_hold();
        repeat (2) @(negedge clk);
        chk("hold_busy", 64'(bus.busy), 0);
        chk("hold_done", 64'(bus.done), 0);
        chk("hold_found", 64'(bus.found), 64'(last_exp.found));
        chk("hold_index", 64'(bus.index), 64'(last_exp.index));
        chk("hold_count", 64'(bus.count), 64'(last_exp.count));
    endtask

    initial begin
        bool_init();
    end

    task automatic bool_init();
        int k;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.vec   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_found", 64'(bus.found), 0);
        chk("rst_index", 64'(bus.index), 0);
        chk("rst_count", 64'(bus.count), 0);
        reset = 1'b0;

        run_scan(32'h0000_0000, 1'b0); wait_idle();
        run_scan(32'h0001_0010, 1'b0); wait_idle();
        run_scan(32'h0001_0010, 1'b1); wait_idle();
        check_hold();
        run_scan(32'hFFFF_FFFF, 1'b1); wait_idle();
        run_scan(32'h8000_0000, 1'b0); wait_idle();
        run_scan(32'h8000_0000, 1'b1); wait_idle();
        check_hold();

        // Start pulse and vec/mode change mid-scan must be ignored.
        run_scan(32'h0001_0010, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.vec   = 32'hFFFF_FFFF;
        bus.mode  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        check_hold();

        // Start held high through the scan and into the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.vec   = 32'h0300_0C00;
        bus.mode  = 1'b0;
        push(32'h0300_0C00, 1'b0);
        k = 0;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) chk("b2b_timeout", 0, 1);
        bus.vec  = 32'h0300_0C00;
        bus.mode = 1'b1;
        push(32'h0300_0C00, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", 64'(bus.busy), 1);
        wait_idle();
        check_hold();

        // Reset in the middle of a scan aborts it without a done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.vec   = 32'hFFFF_FFFF;
        bus.mode  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 0);
        chk("abort_done", 64'(bus.done), 0);
        chk("abort_found", 64'(bus.found), 0);
        chk("abort_index", 64'(bus.index), 0);
        chk("abort_count", 64'(bus.count), 0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(bus.done), 0);
        run_scan(32'h0000_8001, 1'b1); wait_idle();

        for (int n = 0; n < 8; n++) begin
            logic [31:0] v;
            v = $urandom;
            if (n == 0) v = v & 32'h0000_F000;
            run_scan(v, 1'(n & 1));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask
endmodule
